sseg_scan_driver: RTL



---
 rtl/sseg_scan_driver.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/sseg_scan_driver.sv
// ============================================================================
// sseg_scan_driver : binary -> BCD (double dabble) multiplexed 7-seg driver
// Optional build macro: SSEG_LEADING_ZERO_BLANK_EN (blank leading zero digits)
// Revision: 1.0
// ============================================================================
`default_nettype none

module sseg_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int VAL_W       = 14,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [VAL_W-1:0]      value,
    input  logic                  load,
    output logic                  busy,
    output logic                  overflow,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            sseg
);

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    localparam int              C_BCD_W   = 4 * NUM_DIGITS;
    localparam int              C_ITER_W  = $clog2(VAL_W + 1);
    localparam int              C_REF_W   = $clog2(REFRESH_DIV);
    localparam int              C_IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [VAL_W-1:0] C_MAX_VAL = VAL_W'(pow10(NUM_DIGITS) - 1);
    localparam logic [6:0]      C_DASH    = 7'b0111111;
    localparam logic [6:0]      C_BLANK   = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t                 state_q,     state_d;
    logic [VAL_W-1:0]       shift_q,     shift_d;
    logic [C_BCD_W-1:0]     bcd_acc_q,   bcd_acc_d;
    logic [C_ITER_W-1:0]    iter_q,      iter_d;
    logic                   ovf_next_q,  ovf_next_d;
    logic                   busy_q,      busy_d;
    logic [C_BCD_W-1:0]     disp_bcd_q,  disp_bcd_d;
    logic                   overflow_q,  overflow_d;
    logic [C_REF_W-1:0]     refresh_q,   refresh_d;
    logic [C_IDX_W-1:0]     idx_q,       idx_d;
    logic [NUM_DIGITS-1:0]  an_q,        an_d;
    logic [6:0]             sseg_q,      sseg_d;

    logic [C_BCD_W-1:0]     bcd_adj;
    logic [3:0]             sel_nib;
    logic                   blank_digit;

    // Conversion FSM: capture, VAL_W add-3/shift steps, then commit to display
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bcd_acc_d  = bcd_acc_q;
        iter_d     = iter_q;
        ovf_next_d = ovf_next_q;
        busy_d     = busy_q;
        disp_bcd_d = disp_bcd_q;
        overflow_d = overflow_q;

        bcd_adj = bcd_acc_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_adj[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    shift_d    = value;
                    bcd_acc_d  = '0;
                    iter_d     = '0;
                    ovf_next_d = (value > C_MAX_VAL);
                    busy_d     = 1'b1;
                    state_d    = ST_CONV;
                end
            end
            ST_CONV: begin
                {bcd_acc_d, shift_d} = {bcd_adj[C_BCD_W-2:0], shift_q, 1'b0};
                iter_d = iter_q + C_ITER_W'(1);
                if (iter_q == C_ITER_W'(VAL_W - 1)) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                disp_bcd_d = bcd_acc_q;
                overflow_d = ovf_next_q;
                busy_d     = 1'b0;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Digit scan runs independently of the conversion engine
    always_comb begin
        refresh_d = refresh_q + C_REF_W'(1);
        idx_d     = idx_q;
        if (refresh_q == C_REF_W'(REFRESH_DIV - 1)) begin
            refresh_d = '0;
            idx_d     = (idx_q == C_IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + C_IDX_W'(1);
        end

        sel_nib = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == C_IDX_W'(i)) sel_nib = disp_bcd_q[4*i +: 4];
        end

        blank_digit = 1'b0;
`ifdef SSEG_LEADING_ZERO_BLANK_EN
        begin : g_lead_blank
            logic upper_zero;
            upper_zero = 1'b1;
            for (int i = NUM_DIGITS - 1; i > 0; i--) begin
                upper_zero = upper_zero && (disp_bcd_q[4*i +: 4] == 4'd0);
                if ((idx_q == C_IDX_W'(i)) && upper_zero) blank_digit = 1'b1;
            end
        end
`else
        blank_digit = 1'b0;
`endif

        an_d = ~(NUM_DIGITS'(1) << idx_q);
        if (overflow_q) begin
            sseg_d = C_DASH;
        end else if (blank_digit) begin
            sseg_d = C_BLANK;
        end else begin
            sseg_d = seg_decode(sel_nib);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bcd_acc_q  <= '0;
            iter_q     <= '0;
            ovf_next_q <= 1'b0;
            busy_q     <= 1'b0;
            disp_bcd_q <= '0;
            overflow_q <= 1'b0;
            refresh_q  <= '0;
            idx_q      <= '0;
            an_q       <= '1;
            sseg_q     <= C_BLANK;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bcd_acc_q  <= bcd_acc_d;
            iter_q     <= iter_d;
            ovf_next_q <= ovf_next_d;
            busy_q     <= busy_d;
            disp_bcd_q <= disp_bcd_d;
            overflow_q <= overflow_d;
            refresh_q  <= refresh_d;
            idx_q      <= idx_d;
            an_q       <= an_d;
            sseg_q     <= sseg_d;
        end
    end

    assign busy     = busy_q;
    assign overflow = overflow_q;
    assign an       = an_q;
    assign sseg     = sseg_q;

endmodule

`default_nettype wire
